// File: rtl/gcd_binary_engine_pkg.sv
// gcd_binary_engine_pkg
// Shared definitions for the binary (Stein) GCD engine:
//   - default operand/result width and cycle-counter width
//   - FSM state enumeration used by the top level
package gcd_binary_engine_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gcd_binary_engine_if.sv
// gcd_binary_engine_if
// Start/done control bus of the GCD engine.
//   start        : request, accepted on a rising edge while ready=1
//   opa, opb     : operands, sampled on the accept edge
//   ready        : engine can accept start
//   done         : one-cycle pulse when a result is produced
//   result_valid : result/cycles valid, held until next accept or reset
//   result       : gcd(opa, opb)
//   cycles       : RUN cycles used by the last job (saturating)
// Modports: master = requester, slave = engine.
interface gcd_binary_engine_if
   import gcd_binary_engine_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);

   logic             start;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             ready;
   logic             done;
   logic             result_valid;
   logic [WIDTH-1:0] result;
   logic [CNT_W-1:0] cycles;

   modport master (
      output start, opa, opb,
      input  ready, done, result_valid, result, cycles
   );

   modport slave (
      input  start, opa, opb,
      output ready, done, result_valid, result, cycles
   );

endinterface

// File: rtl/gcd_binary_engine_step.sv
// gcd_step
// One combinational reduction step of the binary GCD algorithm.
//   a, b, k          : current operands and common power-of-two count
//   a_next, b_next,
//   k_next           : operands/count after this step
//   term             : operands have converged (or one is zero)
//   final_val        : gcd value for the terminating step, (a|b) << k
module gcd_step
   import gcd_binary_engine_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int K_W   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [K_W-1:0]   k,
   output logic [WIDTH-1:0] a_next,
   output logic [WIDTH-1:0] b_next,
   output logic [K_W-1:0]   k_next,
   output logic             term,
   output logic [WIDTH-1:0] final_val
);

   logic [WIDTH-1:0] base;

   // gcd(0,x)=x; when a==b either operand is the answer.
   assign base      = (a == '0) ? b : a;
   assign final_val = base << k;

   always_comb begin
      a_next = a;
      b_next = b;
      k_next = k;
      term   = 1'b0;
      if ((a == b) || (a == '0) || (b == '0)) begin
         term = 1'b1;
      end else if (!a[0] && !b[0]) begin
         // Shared factor of two: strip it and remember it in k.
         a_next = a >> 1;
         b_next = b >> 1;
         k_next = k + K_W'(1);
      end else if (!a[0]) begin
         a_next = a >> 1;
      end else if (!b[0]) begin
         b_next = b >> 1;
      end else if (a > b) begin
         // Difference of two odds is even, so the shift is free.
         a_next = (a - b) >> 1;
      end else begin
         b_next = (b - a) >> 1;
      end
   end

endmodule

// File: rtl/gcd_binary_engine.sv
// gcd_binary_engine
// Binary (Stein) GCD engine, one reduction step per clock.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : gcd_binary_engine_if.slave (start/opa/opb in;
//         ready/done/result_valid/result/cycles out)
// The FSM is IDLE -> RUN -> DONE; DONE lasts one cycle and either
// restarts straight into RUN (start held) or falls back to IDLE.
module gcd_binary_engine
   import gcd_binary_engine_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   gcd_binary_engine_if.slave bus
);

   localparam int               K_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [K_W-1:0]   k_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] result_reg;
   logic [CNT_W-1:0] cycles_reg;
   logic             result_valid_reg;

   logic             load;
   logic             step_en;
   logic [CNT_W-1:0] cnt_next;

   logic [WIDTH-1:0] a_next, b_next, final_val;
   logic [K_W-1:0]   k_next;
   logic             term;

   gcd_step #(.WIDTH(WIDTH)) u_step (
      .a         (a_reg),
      .b         (b_reg),
      .k         (k_reg),
      .a_next    (a_next),
      .b_next    (b_next),
      .k_next    (k_next),
      .term      (term),
      .final_val (final_val)
   );

   // Counter saturates so very long jobs with a narrow CNT_W stay readable.
   assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step_en    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            step_en = 1'b1;
            if (term) state_next = ST_DONE;
         end
         ST_DONE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= ST_IDLE;
         a_reg            <= '0;
         b_reg            <= '0;
         k_reg            <= '0;
         cnt_reg          <= '0;
         result_reg       <= '0;
         cycles_reg       <= '0;
         result_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         // Datapath registers only move on accept or while running.
         if (load) begin
            a_reg            <= bus.opa;
            b_reg            <= bus.opb;
            k_reg            <= '0;
            cnt_reg          <= '0;
            result_valid_reg <= 1'b0;
         end else if (step_en) begin
            cnt_reg <= cnt_next;
            if (term) begin
               result_reg       <= final_val;
               cycles_reg       <= cnt_next;
               result_valid_reg <= 1'b1;
            end else begin
               a_reg <= a_next;
               b_reg <= b_next;
               k_reg <= k_next;
            end
         end
      end
   end

   assign bus.ready        = (state_reg != ST_RUN);
   assign bus.done         = (state_reg == ST_DONE);
   assign bus.result_valid = result_valid_reg;
   assign bus.result       = result_reg;
   assign bus.cycles       = cycles_reg;

endmodule
